operand_fetch_stage: RTL and testbench

- Upstream neighbour of the ALU. Holds the architectural register file and reads rs/rt.
- Selects operand B as either the register value or the extended 16-bit immediate.
- Registers operandA, operandB and aluOp into a one-entry valid/ready pipeline register that drives the ALU inputs directly.
- Also accepts the writeback port from the result stage.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/reg_file.sv | 66 ++++++
 rtl/operand_fetch_stage.sv | 103 ++++++++++
 tb/tb_operand_fetch_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU opcode encodings, default datapath widths and the
//               16-bit immediate extension helper.
// Revision    : 1.0 - initial release
// ============================================================================

package alu_pkg;

    localparam int c_DATA_WIDTH = 32;
    localparam int c_ADDR_WIDTH = 5;
    localparam int c_REG_COUNT  = 32;
    localparam int c_IMM_WIDTH  = 16;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100
    } alu_op_e;

    // Zero-extend, or replicate imm[15] when sign_ext is set.
    function automatic logic [c_DATA_WIDTH-1:0] extend_imm(
        input logic [c_IMM_WIDTH-1:0] imm,
        input logic                   sign_ext
    );
        logic fill;
        fill = sign_ext & imm[c_IMM_WIDTH-1];
        return {{(c_DATA_WIDTH-c_IMM_WIDTH){fill}}, imm};
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : Architectural register file, two combinational read ports,
//               one write port, hard-wired zero register. Optional same-cycle
//               write-through selected by macro OPFETCH_WB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================

module reg_file
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int REG_COUNT  = c_REG_COUNT,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] rsAddr,
    input  logic [ADDR_WIDTH-1:0] rtAddr,
    output logic [DATA_WIDTH-1:0] rsData,
    output logic [DATA_WIDTH-1:0] rtData,
    input  logic                  wbEnable,
    input  logic [ADDR_WIDTH-1:0] wbAddr,
    input  logic [DATA_WIDTH-1:0] wbData
);

    localparam logic [ADDR_WIDTH:0] c_REG_LIMIT = (ADDR_WIDTH+1)'(REG_COUNT);

    logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];

    logic                  w_wr_en;
    logic                  w_rs_valid;
    logic                  w_rt_valid;
    logic [DATA_WIDTH-1:0] w_rs_raw;
    logic [DATA_WIDTH-1:0] w_rt_raw;

    // Address 0 and addresses beyond REG_COUNT never hold data.
    assign w_wr_en    = wbEnable && (wbAddr != '0) && ({1'b0, wbAddr} < c_REG_LIMIT);
    assign w_rs_valid = (rsAddr != '0) && ({1'b0, rsAddr} < c_REG_LIMIT);
    assign w_rt_valid = (rtAddr != '0) && ({1'b0, rtAddr} < c_REG_LIMIT);

    assign w_rs_raw = w_rs_valid ? r_regs[rsAddr] : '0;
    assign w_rt_raw = w_rt_valid ? r_regs[rtAddr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[wbAddr] <= wbData;
        end
    end

`ifdef OPFETCH_WB_BYPASS_EN
    assign rsData = (w_wr_en && (rsAddr == wbAddr)) ? wbData : w_rs_raw;
    assign rtData = (w_wr_en && (rtAddr == wbAddr)) ? wbData : w_rt_raw;
`else
    assign rsData = w_rs_raw;
    assign rtData = w_rt_raw;
`endif

endmodule

`default_nettype wire

// File: rtl/operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_stage
// Description : Reads rs/rt, selects operand B (register or extended
//               immediate) and holds operands in a one-entry valid/ready
//               register feeding the ALU. Macro: OPFETCH_WB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================

module operand_fetch_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int REG_COUNT  = c_REG_COUNT,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inValid,
    output logic                   inReady,
    input  logic [ADDR_WIDTH-1:0]  rsAddr,
    input  logic [ADDR_WIDTH-1:0]  rtAddr,
    input  logic [c_IMM_WIDTH-1:0] immediate,
    input  logic                   aluSrcImm,
    input  logic                   signExtend,
    input  logic [2:0]             aluOpIn,
    input  logic                   wbEnable,
    input  logic [ADDR_WIDTH-1:0]  wbAddr,
    input  logic [DATA_WIDTH-1:0]  wbData,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [DATA_WIDTH-1:0]  operandA,
    output logic [DATA_WIDTH-1:0]  operandB,
    output logic [2:0]             aluOp
);

    logic [DATA_WIDTH-1:0] w_rs_data;
    logic [DATA_WIDTH-1:0] w_rt_data;
    logic [DATA_WIDTH-1:0] w_imm_ext;
    logic [DATA_WIDTH-1:0] w_operand_b;
    logic                  w_capture;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_operand_a;
    logic [DATA_WIDTH-1:0] r_operand_b;
    logic [2:0]            r_alu_op;

    reg_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_reg_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .rsAddr   (rsAddr),
        .rtAddr   (rtAddr),
        .rsData   (w_rs_data),
        .rtData   (w_rt_data),
        .wbEnable (wbEnable),
        .wbAddr   (wbAddr),
        .wbData   (wbData)
    );

    // The package helper is fixed at the default width; other widths inline it.
    generate
        if (DATA_WIDTH == c_DATA_WIDTH) begin : g_ext_pkg
            assign w_imm_ext = extend_imm(immediate, signExtend);
        end else begin : g_ext_generic
            assign w_imm_ext = {{(DATA_WIDTH-c_IMM_WIDTH){signExtend & immediate[c_IMM_WIDTH-1]}},
                                immediate};
        end
    endgenerate

    assign w_operand_b = aluSrcImm ? w_imm_ext : w_rt_data;

    assign inReady   = !r_out_valid || outReady;
    assign w_capture = inValid && inReady;

    // Capture wins over drain, so back-to-back transfers keep outValid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_operand_a <= '0;
            r_operand_b <= '0;
            r_alu_op    <= ALU_ADD;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_operand_a <= w_rs_data;
            r_operand_b <= w_operand_b;
            r_alu_op    <= aluOpIn;
        end else if (outReady) begin
            r_out_valid <= 1'b0;
        end
    end

    assign outValid = r_out_valid;
    assign operandA = r_operand_a;
    assign operandB = r_operand_b;
    assign aluOp    = r_alu_op;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch_stage
// Description : Scoreboard bench for operand_fetch_stage: directed scenarios
//               followed by randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inValid;
    logic        inReady;
    logic [4:0]  rsAddr;
    logic [4:0]  rtAddr;
    logic [15:0] immediate;
    logic        aluSrcImm;
    logic        signExtend;
    logic [2:0]  aluOpIn;
    logic        wbEnable;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic        outValid;
    logic        outReady;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic [2:0]  aluOp;

    operand_fetch_stage #(
        .DATA_WIDTH (32),
        .REG_COUNT  (32),
        .ADDR_WIDTH (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inValid    (inValid),
        .inReady    (inReady),
        .rsAddr     (rsAddr),
        .rtAddr     (rtAddr),
        .immediate  (immediate),
        .aluSrcImm  (aluSrcImm),
        .signExtend (signExtend),
        .aluOpIn    (aluOpIn),
        .wbEnable   (wbEnable),
        .wbAddr     (wbAddr),
        .wbData     (wbData),
        .outValid   (outValid),
        .outReady   (outReady),
        .operandA   (operandA),
        .operandB   (operandB),
        .aluOp      (aluOp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } entry_t;

    entry_t      sb[$];
    logic [31:0] m_regs [32];
    logic        m_valid = 1'b0;
    int          n_cmp   = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'd0;
`ifdef OPFETCH_WB_BYPASS_EN
        if (wbEnable && wbAddr == a) return wbData;
`endif
        return m_regs[a];
    endfunction

    function automatic logic [31:0] m_ext(input logic [15:0] imm, input logic sx);
        if (sx) return 32'($signed(imm));
        return 32'(imm);
    endfunction

    // Reference model: decides acceptance from its own occupancy bit.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("inReady", 32'(inReady), 32'(!m_valid || outReady));
            if (inValid && (!m_valid || outReady)) begin
                entry_t e;
                e.a  = m_read(rsAddr);
                e.b  = aluSrcImm ? m_ext(immediate, signExtend) : m_read(rtAddr);
                e.op = aluOpIn;
                sb.push_back(e);
                m_valid <= 1'b1;
            end else if (outReady) begin
                m_valid <= 1'b0;
            end
            if (wbEnable && wbAddr != 0) m_regs[wbAddr] = wbData;
        end
    end

    always @(negedge rst_n) begin
        m_valid <= 1'b0;
        sb.delete();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    end

    // Monitor: the presented entry must match the scoreboard head every cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("outValid", 32'(outValid), 32'(m_valid));
            if (outValid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("sb_nonempty", 32'd0, 32'd1);
                end else begin
                    check("operandA", operandA, sb[0].a);
                    check("operandB", operandB, sb[0].b);
                    check("aluOp", 32'(aluOp), 32'(sb[0].op));
                    if (outReady) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wbEnable = 1'b1;
        wbAddr   = a;
        wbData   = d;
    endtask

    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm,
                         input logic src, input logic sx, input logic [2:0] op);
        inValid    = 1'b1;
        rsAddr     = rs;
        rtAddr     = rt;
        immediate  = imm;
        aluSrcImm  = src;
        signExtend = sx;
        aluOpIn    = op;
    endtask

    task automatic idle();
        inValid  = 1'b0;
        wbEnable = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_outValid"}, 32'(outValid), 32'd0);
        check({tag, "_operandA"}, operandA, 32'd0);
        check({tag, "_operandB"}, operandB, 32'd0);
        check({tag, "_aluOp"}, 32'(aluOp), 32'd0);
        check({tag, "_inReady"}, 32'(inReady), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        rst_n = 1'b0;
        idle();
        rsAddr = '0; rtAddr = '0; immediate = '0; aluSrcImm = 1'b0;
        signExtend = 1'b0; aluOpIn = '0; wbAddr = '0; wbData = '0;
        outReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // Register operands after writeback.
        wb(5'd5, 32'h0000_0010); step();
        wb(5'd6, 32'h0000_0003); step();
        wbEnable = 1'b0;
        issue(5'd5, 5'd6, 16'h0, 1'b0, 1'b0, 3'b001); step();
        inValid = 1'b0; step();

        // Immediate extension, both modes, back to back.
        issue(5'd5, 5'd0, 16'hFFFE, 1'b1, 1'b1, 3'b000); step();
        issue(5'd5, 5'd0, 16'hFFFE, 1'b1, 1'b0, 3'b010); step();
        inValid = 1'b0; step();

        // Writes to x0 are discarded.
        wb(5'd0, 32'hDEAD_BEEF); step();
        wbEnable = 1'b0;
        issue(5'd0, 5'd0, 16'h0, 1'b0, 1'b0, 3'b011); step();
        inValid = 1'b0; step();

        // Stall with changing upstream inputs, then release.
        issue(5'd5, 5'd6, 16'h0, 1'b0, 1'b0, 3'b100); step();
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(5'(i + 1), 5'd6, 16'(i * 7), 1'(i & 1), 1'b1, 3'(i));
            step();
        end
        outReady = 1'b1; step();
        inValid = 1'b0; step();

        // Same-cycle writeback and read of x7.
        wb(5'd7, 32'hAAAA_5555); step();
        wb(5'd7, 32'h0000_1234);
        issue(5'd7, 5'd7, 16'h0, 1'b0, 1'b0, 3'b000); step();
        idle(); step();

        // Randomized traffic with random backpressure and writeback.
        for (int i = 0; i < 400; i++) begin
            inValid    = 1'($urandom_range(0, 1));
            rsAddr     = 5'($urandom);
            rtAddr     = 5'($urandom);
            immediate  = 16'($urandom);
            aluSrcImm  = 1'($urandom_range(0, 1));
            signExtend = 1'($urandom_range(0, 1));
            aluOpIn    = 3'($urandom_range(0, 4));
            wbEnable   = 1'($urandom_range(0, 1));
            wbAddr     = 5'($urandom);
            wbData     = $urandom;
            outReady   = ($urandom_range(0, 3) != 0);
            step();
        end
        idle();
        outReady = 1'b1;
        step(); step();

        // Asynchronous reset in the middle of a stall.
        issue(5'd5, 5'd6, 16'h0, 1'b0, 1'b0, 3'b011); step();
        inValid  = 1'b0;
        outReady = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        outReady = 1'b1;
        step();
        issue(5'd5, 5'd6, 16'h0, 1'b0, 1'b0, 3'b001); step();
        issue(5'd7, 5'd6, 16'h0, 1'b0, 1'b0, 3'b010); step();
        idle();
        repeat (3) step();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
